// File: rtl/iccm_port_arb.sv
// ICCM port arbiter: programmer image load via a 2-entry write FIFO, then bus pass-through while the core runs.
// Bus grants are combinational (zero latency); programmer words are dropped (sticky ovf_o) only when the FIFO is full and not popping.
module iccm_port_arb #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          prog_we_i,
    input  logic [AW-1:0] prog_addr_i,
    input  logic [DW-1:0] prog_wdata_i,
    input  logic          prog_done_i,
    input  logic          bus_req_i,
    input  logic          bus_we_i,
    input  logic [AW-1:0] bus_addr_i,
    input  logic [DW-1:0] bus_wdata_i,
    input  logic [DW-1:0] bus_wmask_i,
    output logic          bus_gnt_o,
    output logic          bus_rvalid_o,
    output logic [DW-1:0] bus_rdata_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [DW-1:0] mem_wmask_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_rvalid_i,
    output logic          core_rst_o,
    output logic [AW:0]   prog_count_o,
    output logic          ovf_o
);

    typedef enum logic [1:0] {LOAD, DRAIN, RUN, QUIESCE} state_t;

    localparam logic [AW:0] PC_MAX = {1'b1, {AW{1'b0}}};

    state_t        state, state_nxt;
    logic [AW-1:0] fifo_addr [2];
    logic [DW-1:0] fifo_data [2];
    logic          rd_ptr, wr_ptr;
    logic [1:0]    fifo_cnt;
    logic          fifo_empty, fifo_full;
    logic          push, pop, drop;
    logic          gnt, rd_acc;
    logic [1:0]    outst;

    assign fifo_empty = (fifo_cnt == 2'd0);
    assign fifo_full  = (fifo_cnt == 2'd2);
    assign pop        = ((state == LOAD) || (state == DRAIN)) && !fifo_empty;
    // A push into a full FIFO still succeeds when the head leaves in the same cycle.
    assign push       = prog_we_i && (!fifo_full || pop);
    assign drop       = prog_we_i && fifo_full && !pop;
    assign rd_acc     = gnt && !bus_we_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt         = 1'b0;
        core_rst_o  = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        case (state)
            LOAD: begin
                core_rst_o = 1'b1;
                if (prog_done_i) state_nxt = DRAIN;
            end
            DRAIN: begin
                core_rst_o = 1'b1;
                if (fifo_empty && !prog_we_i) state_nxt = RUN;
            end
            RUN: begin
                gnt = bus_req_i && fifo_empty && (outst < 2'd2);
                if (prog_we_i) state_nxt = QUIESCE;
            end
            QUIESCE: begin
                if (outst == 2'd0) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
        if (gnt) begin
            mem_req_o   = 1'b1;
            mem_we_o    = bus_we_i;
            mem_addr_o  = bus_addr_i;
            mem_wdata_o = bus_wdata_i;
            mem_wmask_o = bus_wmask_i;
        end else if (pop) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = fifo_addr[rd_ptr];
            mem_wdata_o = fifo_data[rd_ptr];
            mem_wmask_o = '1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr[wr_ptr] <= prog_addr_i;
            fifo_data[wr_ptr] <= prog_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outst <= 2'd0;
        end else if (rd_acc && !mem_rvalid_i) begin
            outst <= outst + 2'd1;
        end else if (!rd_acc && mem_rvalid_i && (outst != 2'd0)) begin
            outst <= outst - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prog_count_o <= '0;
            ovf_o        <= 1'b0;
        end else begin
            if (drop) ovf_o <= 1'b1;
            if ((state == QUIESCE) && (state_nxt == LOAD)) begin
                prog_count_o <= '0;
            end else if (pop && (prog_count_o != PC_MAX)) begin
                prog_count_o <= prog_count_o + 1'b1;
            end
        end
    end

    assign bus_gnt_o    = gnt;
    assign bus_rvalid_o = mem_rvalid_i;
    assign bus_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_iccm_port_arb.sv
// Bench for iccm_port_arb: queued expectations of memory transactions and read data, plus directed state checks.
module tb_iccm_port_arb;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          prog_we_i;
    logic [AW-1:0] prog_addr_i;
    logic [DW-1:0] prog_wdata_i;
    logic          prog_done_i;
    logic          bus_req_i;
    logic          bus_we_i;
    logic [AW-1:0] bus_addr_i;
    logic [DW-1:0] bus_wdata_i;
    logic [DW-1:0] bus_wmask_i;
    logic          bus_gnt_o;
    logic          bus_rvalid_o;
    logic [DW-1:0] bus_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_wmask_o;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_rvalid_i;
    logic          core_rst_o;
    logic [AW:0]   prog_count_o;
    logic          ovf_o;

    iccm_port_arb #(.AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i), .prog_wdata_i(prog_wdata_i),
        .prog_done_i(prog_done_i),
        .bus_req_i(bus_req_i), .bus_we_i(bus_we_i), .bus_addr_i(bus_addr_i),
        .bus_wdata_i(bus_wdata_i), .bus_wmask_i(bus_wmask_i),
        .bus_gnt_o(bus_gnt_o), .bus_rvalid_o(bus_rvalid_o), .bus_rdata_o(bus_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
        .core_rst_o(core_rst_o), .prog_count_o(prog_count_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] m;
    } txn_t;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } pend_t;

    txn_t          exp_mem[$];
    logic [DW-1:0] exp_rd[$];
    pend_t         pq[$];
    int            lat = 1;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;
    txn_t          mon_e;
    logic [DW-1:0] mon_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {20'h0, a};
    endfunction

    // Memory model: read data returns 'lat' cycles after the request cycle.
    always @(negedge clk) begin
        if (!rst_i && mem_req_o && !mem_we_o) pq.push_back('{cyc + lat, rd_fn(mem_addr_o)});
    end

    initial begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst_i) pq.delete();
            if (pq.size() > 0 && pq[0].due == cyc) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = pq[0].d;
                void'(pq.pop_front());
            end else begin
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (mem_req_o) begin
            if (exp_mem.size() == 0) begin
                chk("mem_unexpected_req", {52'h0, mem_addr_o}, 64'hFFFF);
            end else begin
                mon_e = exp_mem.pop_front();
                chk("mem_we",    mem_we_o,    mon_e.we);
                chk("mem_addr",  mem_addr_o,  mon_e.a);
                chk("mem_wdata", mem_wdata_o, mon_e.d);
                chk("mem_wmask", mem_wmask_o, mon_e.m);
            end
        end
        if (bus_rvalid_o) begin
            if (exp_rd.size() == 0) begin
                chk("rvalid_unexpected", bus_rdata_o, 64'hFFFF_FFFF_FFFF);
            end else begin
                mon_d = exp_rd.pop_front();
                chk("bus_rdata", bus_rdata_o, mon_d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_read(input logic [AW-1:0] a);
        exp_mem.push_back('{1'b0, a, '0, '0});
        exp_rd.push_back(rd_fn(a));
    endtask

    // Presents a bus read for one cycle; leaves bus_req_i high for the caller.
    task automatic bus_read(input logic [AW-1:0] a, input logic exp_gnt, input string tag);
        bus_req_i   = 1'b1;
        bus_we_i    = 1'b0;
        bus_addr_i  = a;
        bus_wdata_i = '0;
        bus_wmask_i = '0;
        if (exp_gnt) exp_read(a);
        @(negedge clk);
        chk(tag, bus_gnt_o, exp_gnt);
        tick();
    endtask

    task automatic drive_pw(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic keep);
        prog_we_i    = 1'b1;
        prog_addr_i  = a;
        prog_wdata_i = d;
        if (keep) exp_mem.push_back('{1'b1, a, d, '1});
    endtask

    task automatic wait_core_rst(input logic v, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (core_rst_o == v) hit = 1'b1;
        end
        chk(tag, core_rst_o, v);
        tick();
    endtask

    task automatic done_pulse();
        prog_done_i = 1'b1;
        tick();
        prog_done_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;  prog_we_i = 1'b0; prog_addr_i = '0; prog_wdata_i = '0; prog_done_i = 1'b0;
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_i = '0; bus_wdata_i = '0; bus_wmask_i = '0;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        chk("rst_gnt",        bus_gnt_o,    0);
        chk("rst_mem_req",    mem_req_o,    0);
        chk("rst_core_rst",   core_rst_o,   1);
        chk("rst_prog_count", prog_count_o, 0);
        chk("rst_ovf",        ovf_o,        0);
        tick();
        rst_i = 1'b0;
        bus_req_i = 1'b0;

        // Image load; done coincides with the last word
        drive_pw(12'h0, 32'hA0, 1); tick();
        drive_pw(12'h1, 32'hA1, 1); tick();
        drive_pw(12'h2, 32'hA2, 1); prog_done_i = 1'b1; tick();
        prog_we_i = 1'b0; prog_done_i = 1'b0;
        wait_core_rst(0, "load_run_entry");
        chk("load_prog_count", prog_count_o, 3);

        // Bus write pass-through, then single read with one-cycle return
        bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = 12'h7;
        bus_wdata_i = 32'h1234_5678; bus_wmask_i = 32'h0000_FFFF;
        exp_mem.push_back('{1'b1, 12'h7, 32'h1234_5678, 32'h0000_FFFF});
        @(negedge clk);
        chk("bus_wr_gnt", bus_gnt_o, 1);
        tick();
        bus_read(12'h8, 1, "rd8_gnt");
        bus_req_i = 1'b0;
        @(negedge clk);
        chk("rd8_rvalid_next", bus_rvalid_o, 1);
        tick();
        repeat (2) tick();

        // Two-cycle memory: outstanding limit stalls the third read
        lat = 2;
        bus_read(12'h5, 1, "b2b_gnt0");
        bus_read(12'h6, 1, "b2b_gnt1");
        bus_read(12'h7, 0, "b2b_stall2");
        bus_read(12'h7, 1, "b2b_gnt3");
        bus_req_i = 1'b0;
        repeat (4) tick();

        // Programmer write during RUN with a read in flight
        lat = 1;
        bus_read(12'h20, 1, "q_rd_gnt");
        bus_req_i = 1'b0;
        drive_pw(12'h10, 32'h55, 1);
        tick();
        prog_we_i = 1'b0;
        bus_req_i = 1'b1; bus_addr_i = 12'h21;
        @(negedge clk);
        chk("q_gnt_blocked", bus_gnt_o, 0);
        chk("q_core_rst",    core_rst_o, 0);
        tick();
        bus_req_i = 1'b0;
        wait_core_rst(1, "q_load_entry");
        done_pulse();
        wait_core_rst(0, "q_run_entry");
        chk("q_prog_count", prog_count_o, 1);

        // Overflow while quiescing with two reads outstanding
        lat = 2;
        bus_read(12'h30, 1, "ovf_rd0_gnt");
        bus_addr_i = 12'h31;
        exp_read(12'h31);
        drive_pw(12'h40, 32'hB1, 1);
        @(negedge clk);
        chk("ovf_rd1_gnt", bus_gnt_o, 1);
        tick();
        bus_req_i = 1'b0;
        drive_pw(12'h41, 32'hB2, 1);
        @(negedge clk);
        chk("ovf_before_2", ovf_o, 0);
        tick();
        drive_pw(12'h42, 32'hB3, 0);
        @(negedge clk);
        chk("ovf_before_3", ovf_o, 0);
        tick();
        prog_we_i = 1'b0;
        @(negedge clk);
        chk("ovf_set", ovf_o, 1);
        tick();
        wait_core_rst(1, "ovf_load_entry");
        done_pulse();
        wait_core_rst(0, "ovf_run_entry");
        chk("ovf_prog_count", prog_count_o, 2);
        chk("ovf_sticky", ovf_o, 1);

        // prog_done ignored in RUN; reset discards a full FIFO
        lat = 1;
        done_pulse();
        bus_read(12'h50, 1, "done_ignored_gnt");
        bus_req_i = 1'b0;
        drive_pw(12'h60, 32'h1, 0); tick();
        drive_pw(12'h61, 32'h2, 0); tick();
        rst_i = 1'b1;
        prog_we_i = 1'b0;
        @(negedge clk);
        chk("midrst_mem_req",  mem_req_o,  0);
        chk("midrst_core_rst", core_rst_o, 1);
        repeat (2) tick();
        rst_i = 1'b0;
        @(negedge clk);
        chk("rel_mem_req",    mem_req_o,    0);
        chk("rel_prog_count", prog_count_o, 0);
        chk("rel_ovf",        ovf_o,        0);
        chk("rel_core_rst",   core_rst_o,   1);
        tick();
        repeat (3) tick();

        chk("sb_mem_left", exp_mem.size(), 0);
        chk("sb_rd_left",  exp_rd.size(),  0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
